// File: rtl/ks_audio_pkg.sv
// Shared constants and helpers for the KS audio path: serial framing modes and
// frame/slot arithmetic used by the transmitter, the KS core and the SPI regmap.
package ks_audio_pkg;

   localparam logic MODE_I2S = 1'b0;
   localparam logic MODE_LJ  = 1'b1;

   function automatic int frame_bits(input int num_ch, input int audio_dw);
      return num_ch * audio_dw;
   endfunction

   // Slot that owns a given bit position within a frame.
   function automatic int slot_index(input int bit_idx, input int audio_dw);
      return bit_idx / audio_dw;
   endfunction

endpackage

// File: rtl/ks_sck_gen.sv
// Serial bit clock generator: divides clk into SCK and flags the launch (SCK fall)
// and capture (SCK rise) ticks. The first tick after enable is always a launch.
module ks_sck_gen #(
   parameter int SCK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic sck_o,
   output logic launch_o,
   output logic capture_o,
   output logic first_o
);

   localparam int CW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(SCK_DIV - 1);

   logic [CW-1:0] div_cnt_q, div_cnt_d;
   logic          sck_q, sck_d;
   logic          first_q, first_d;

   // NOTE: every variable gets a default before any branch, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      div_cnt_d = div_cnt_q;
      sck_d     = sck_q;
      first_d   = first_q;
      launch_o  = 1'b0;
      capture_o = 1'b0;
      if (!en_i) begin
         div_cnt_d = '0;
         sck_d     = 1'b0;
         first_d   = 1'b1;
      end else if (div_cnt_q == DIV_LAST) begin
         div_cnt_d = '0;
         // SCK idles low, so the first wrap after enable is treated as a fall.
         if (sck_q || first_q) begin
            launch_o = 1'b1;
            sck_d    = 1'b0;
            first_d  = 1'b0;
         end else begin
            capture_o = 1'b1;
            sck_d     = 1'b1;
         end
      end else begin
         div_cnt_d = div_cnt_q + CW'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         sck_q     <= 1'b0;
         first_q   <= 1'b1;
      end else begin
         div_cnt_q <= div_cnt_d;
         sck_q     <= sck_d;
         first_q   <= first_d;
      end
   end

   assign sck_o   = sck_q;
   assign first_o = first_q;

endmodule

// File: rtl/ks_tdm_audio_tx.sv
// KS audio transmitter: serialises NUM_CH slots of AUDIO_DW bits as I2S (2 slots)
// or TDM (frame-sync pulse), with a double-buffered valid/ready sample input.
module ks_tdm_audio_tx
   import ks_audio_pkg::*;
#(
   parameter int AUDIO_DW = 8,
   parameter int NUM_CH   = 2,
   parameter int SCK_DIV  = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en_i,
   input  logic                       mode_i,
   input  logic [NUM_CH*AUDIO_DW-1:0] sample_i,
   input  logic                       sample_valid_i,
   output logic                       sample_ready_o,
   output logic                       sck_o,
   output logic                       ws_o,
   output logic                       sd_o,
   output logic                       frame_start_o,
   output logic                       underrun_o
);

   localparam int FRAME_BITS = frame_bits(NUM_CH, AUDIO_DW);
   localparam int BW         = $clog2(FRAME_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

   logic                  launch, first_tick, unused_capture;
   logic                  load, boundary;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] hold_q, hold_d, hold_serial;
   logic [FRAME_BITS-1:0] shift_q, shift_d, tx_word;
   logic                  hold_full_q, hold_full_d;
   logic                  mode_q, mode_d;
   logic                  sd_q, sd_d, ws_q, ws_d, fs_q, fs_d, ur_q, ur_d;
   logic [BW:0]           ws_pos;

   ks_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en_i),
      .sck_o     (sck_o),
      .launch_o  (launch),
      .capture_o (unused_capture),
      .first_o   (first_tick)
   );

   // Slot 0 sits in the low bits of sample_i but must leave the shifter first.
   always_comb begin
      hold_serial = '0;
      for (int k = 0; k < NUM_CH; k++)
         hold_serial[(NUM_CH-1-k)*AUDIO_DW +: AUDIO_DW] = hold_q[k*AUDIO_DW +: AUDIO_DW];
   end

   assign load     = sample_valid_i & ~hold_full_q;
   assign boundary = launch & (first_tick | (bit_cnt_q == LAST_BIT));

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      hold_d      = hold_q;
      shift_d     = shift_q;
      mode_d      = mode_q;
      sd_d        = sd_q;
      ws_d        = ws_q;
      fs_d        = 1'b0;
      ur_d        = 1'b0;
      tx_word     = shift_q;
      ws_pos      = '0;
      if (load) hold_d = sample_i;
      // A boundary consumes the old holding word before a same-cycle load refills it.
      hold_full_d = (hold_full_q & ~boundary) | load;
      if (!en_i) begin
         bit_cnt_d = '0;
         shift_d   = '0;
         sd_d      = 1'b0;
         ws_d      = 1'b0;
      end else if (launch) begin
         if (boundary) begin
            mode_d    = mode_i;
            fs_d      = 1'b1;
            bit_cnt_d = '0;
            if (hold_full_q) begin
               tx_word = hold_serial;
            end else begin
               tx_word = '0;
               ur_d    = 1'b1;
            end
         end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
         end
         sd_d    = tx_word[FRAME_BITS-1];
         shift_d = tx_word << 1;
         // WS runs one bit ahead of the data in I2S mode.
         ws_pos  = {1'b0, bit_cnt_d} + (BW+1)'(mode_d == MODE_I2S);
         if (ws_pos == (BW+1)'(FRAME_BITS)) ws_pos = '0;
         if (NUM_CH == 2) ws_d = (ws_pos >= (BW+1)'(AUDIO_DW));
         else             ws_d = (ws_pos == '0);
      end
   end

   // NOTE: the holding and shift registers are reset along with the control
   // state, so a frame after reset can never replay stale audio.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         mode_q      <= MODE_I2S;
         sd_q        <= 1'b0;
         ws_q        <= 1'b0;
         fs_q        <= 1'b0;
         ur_q        <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         mode_q      <= mode_d;
         sd_q        <= sd_d;
         ws_q        <= ws_d;
         fs_q        <= fs_d;
         ur_q        <= ur_d;
      end
   end

   assign sample_ready_o = ~hold_full_q;
   assign sd_o           = sd_q;
   assign ws_o           = ws_q;
   assign frame_start_o  = fs_q;
   assign underrun_o     = ur_q;

endmodule
